// File: rtl/cla_pipe_alu.sv
// cla_pipe_alu -- two-stage pipelined carry-lookahead add/subtract unit.
//
// Stage 1 registers the effective operands (a, Be = b or ~b, Ci) as per-bit
// generate/propagate plus per-group G/P. Stage 2 resolves the group carries
// by lookahead, ripples inside each group, and registers sum and flags.
// A valid/ready handshake with backpressure moves beats through both stages
// in order.
//
// Parameters:
//   WIDTH  operand/result width (>= 4, multiple of GROUP)
//   GROUP  lookahead group size in bits
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake
//   a, b, op, cin         operands; op 00 ADD, 01 ADC, 10 SUB, 11 SBB
//   out_valid / out_ready result beat handshake
//   sum, co, v, z, n      result, carry-out, signed overflow, zero, negative
//
// Optional feature macro: CLA_PIPE_SATURATE_EN
//   When defined, a signed overflow clamps sum to the most positive or most
//   negative value (by the sign of a); v and co still report the raw result,
//   while z and n follow the clamped sum. When undefined, sum wraps.

module cla_pipe_alu #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  // Stage 1 input-side logic
  logic [WIDTH-1:0] be_in;
  logic             ci_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic [NG-1:0]    gg_in;
  logic [NG-1:0]    gp_in;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_a_msb;
  logic             s1_be_msb;
  logic             s1_ci;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [NG-1:0]    s1_gg;
  logic [NG-1:0]    s1_gp;

  // Stage 2 logic
  logic             s2_valid;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_fin;
  logic             v_raw;
  logic             rc;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // SUB/SBB invert b; ADD forces Ci=0, SUB forces Ci=1, ADC/SBB take cin.
  assign be_in = op[1] ? ~b : b;
  assign ci_in = op[0] ? cin : op[1];
  assign g_in  = a & be_in;
  assign p_in  = a ^ be_in;

  // Group generate/propagate: walking bits low to high leaves
  // G = g[top] | p[top] & (g[top-1] | ...).
  always_comb begin
    gg_in = '0;
    gp_in = '1;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GROUP; k++) begin
        gg_in[j] = g_in[j*GROUP+k] | (p_in[j*GROUP+k] & gg_in[j]);
        gp_in[j] = gp_in[j] & p_in[j*GROUP+k];
      end
    end
  end

  // Group carries from G/P, then ripple inside each group from its carry-in.
  always_comb begin
    gc      = '0;
    gc[0]   = s1_ci;
    sum_raw = '0;
    rc      = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gc[j+1] = s1_gg[j] | (s1_gp[j] & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      rc = gc[j];
      for (int k = 0; k < GROUP; k++) begin
        sum_raw[j*GROUP+k] = s1_p[j*GROUP+k] ^ rc;
        rc = s1_g[j*GROUP+k] | (s1_p[j*GROUP+k] & rc);
      end
    end
  end

  assign v_raw = (s1_a_msb == s1_be_msb) && (sum_raw[MSB] != s1_a_msb);

`ifdef CLA_PIPE_SATURATE_EN
  assign sum_fin = !v_raw  ? sum_raw :
                   s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_fin = sum_raw;
`endif

  // Only the sign bits of a/Be are kept past stage 1; g/p carry the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a_msb  <= 1'b0;
      s1_be_msb <= 1'b0;
      s1_ci     <= 1'b0;
      s1_g      <= '0;
      s1_p      <= '0;
      s1_gg     <= '0;
      s1_gp     <= '0;
      s2_valid  <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a_msb  <= a[MSB];
          s1_be_msb <= be_in[MSB];
          s1_ci     <= ci_in;
          s1_g      <= g_in;
          s1_p      <= p_in;
          s1_gg     <= gg_in;
          s1_gp     <= gp_in;
        end
      end
      // Result registers only change on an advance, so they stay stable
      // while a stalled beat waits for out_ready.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          sum <= sum_fin;
          co  <= gc[NG];
          v   <= v_raw;
          z   <= (sum_fin == '0);
          n   <= sum_fin[MSB];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_alu.sv
module tb_cla_pipe_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        v;
  logic        z;
  logic        n;

  int applied;
  int miscompares;
  int pops;

  logic [19:0] expq[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [15:0] sum;
    logic        co;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  vec_t tbl[12];

  cla_pipe_alu #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the effective operands.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [1:0] mop, input logic mcin);
    longint ua, ube, ci, r, sa, sbe, sr;
    logic [15:0] s;
    logic c, ov;
    ua  = {48'b0, ma};
    ube = mop[1] ? {48'b0, ~mb} : {48'b0, mb};
    ci  = (mop == 2'b00) ? 0 : (mop == 2'b10) ? 1 : {63'b0, mcin};
    r   = ua + ube + ci;
    s   = r[15:0];
    c   = r[16];
    sa  = ma[15] ? ua - 65536 : ua;
    sbe = ube >= 32768 ? ube - 65536 : ube;
    sr  = sa + sbe + ci;
    ov  = (sr > 32767) || (sr < -32768);
`ifdef CLA_PIPE_SATURATE_EN
    if (ov) s = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return {s, c, ov, (s == 16'h0000), s[15]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic new_beat();
    int sel;
    sel = $urandom_range(0, 7);
    a   = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h7FFF : (sel == 2) ? 16'h8000 : 16'($urandom);
    sel = $urandom_range(0, 7);
    b   = (sel == 0) ? 16'h0001 : (sel == 1) ? 16'h0000 : (sel == 2) ? 16'h8000 : 16'($urandom);
    op  = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
  endtask

  // One clock with scoreboard bookkeeping; inputs are set by the caller.
  task automatic cyc(output logic acc);
    logic [19:0] e;
    #1;
    acc = in_valid && in_ready;
    if (acc) expq.push_back(model(a, b, op, cin));
    if (out_valid && out_ready) begin
      pops++;
      if (expq.size() == 0) begin
        chk("sb_unexpected_beat", 32'(1), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("sb_result", 32'({sum, co, v, z, n}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    logic [19:0] held;
    int cnt;

    applied = 0; miscompares = 0; pops = 0;
    clk = 0; rst = 1; in_valid = 0; a = 0; b = 0; op = 0; cin = 0; out_ready = 0;

    tbl[0]  = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{16'h0005, 16'h0007, 2'b10, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{16'h0007, 16'h0007, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0000, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16'h0000, 16'h0000, 2'b11, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{16'h8000, 16'h0001, 2'b10, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'h1234, 16'h1111, 2'b01, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0001, 16'h0001, 2'b00, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'h0003, 16'h0001, 2'b10, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'h0005, 16'h0003, 2'b11, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef CLA_PIPE_SATURATE_EN
    tbl[0] = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 2'b00, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h8000, 16'h0001, 2'b10, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`endif

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_flags", 32'({co, v, z, n}), 32'(0));
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    // Directed table: one beat at a time, latency and every field checked
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a; b = tbl[i].b; op = tbl[i].op; cin = tbl[i].cin; in_valid = 1;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 0;
      cnt = 0;
      while (!out_valid && cnt < 5) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("tbl_latency", 32'(cnt), 32'(1));
      chk("tbl_sum", 32'(sum), 32'(tbl[i].sum));
      chk("tbl_co", 32'(co), 32'(tbl[i].co));
      chk("tbl_v", 32'(v), 32'(tbl[i].v));
      chk("tbl_z", 32'(z), 32'(tbl[i].z));
      chk("tbl_n", 32'(n), 32'(tbl[i].n));
      @(posedge clk); #1;
      chk("tbl_drained", 32'(out_valid), 32'(0));
    end

    // Back-to-back 8 beats, out_ready held high
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      if (c < 8) new_beat();
      #1;
      chk("b2b_out_valid", 32'(out_valid), 32'((c >= 2) && (c <= 9)));
      cyc(acc);
    end
    chk("b2b_sb_empty", 32'(expq.size()), 32'(0));

    // Stall: out_ready low for 5 cycles with in_valid high
    out_ready = 0;
    in_valid  = 1;
    new_beat();
    held = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'(c < 2));
      if (c == 2) held = {sum, co, v, z, n};
      if (c > 2) chk("stall_stable", 32'({sum, co, v, z, n}), 32'(held));
      cyc(acc);
      if (acc) new_beat();
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      cyc(acc);
      if (acc) new_beat();
    end
    in_valid = 0;
    for (int c = 0; c < 4; c++) cyc(acc);
    chk("stall_sb_empty", 32'(expq.size()), 32'(0));

    // Randomized traffic with random backpressure
    acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        new_beat();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(acc);
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 5; c++) cyc(acc);
    chk("rand_sb_empty", 32'(expq.size()), 32'(0));

    // Asynchronous reset with both stages holding beats
    out_ready = 0; in_valid = 1;
    new_beat(); cyc(acc);
    new_beat(); cyc(acc);
    in_valid = 0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'(1));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    #1; rst = 1; #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_outputs", 32'({sum, co, v, z, n}), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    expq.delete();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    pops = 0;
    out_ready = 1; in_valid = 1;
    a = 16'h1234; b = 16'h0001; op = 2'b00; cin = 0;
    cyc(acc);
    in_valid = 0;
    for (int c = 0; c < 4; c++) cyc(acc);
    chk("post_rst_pops", 32'(pops), 32'(1));
    chk("post_rst_sb_empty", 32'(expq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
